// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor: checks the SDRAM power-up command sequence, its spacing, refresh count and timeout,
// reporting a sticky first-error code, the captured mode register and init_done.
module sdram_init_monitor #(
   parameter int PWRUP_CYCLES = 10000,
   parameter int NUM_AREF     = 2,
   parameter int T_RP         = 2,
   parameter int T_RFC        = 7,
   parameter int T_MRD        = 2,
   parameter int TIMEOUT      = 0,
   parameter int ADDR_W       = 13
) (
   input  logic              sdram_clk,
   input  logic              sdram_resetn,
   input  logic              sdram_en,
   input  logic              sdram_cs_n,
   input  logic              sdram_ras_n,
   input  logic              sdram_cas_n,
   input  logic              sdram_we_n,
   input  logic [ADDR_W-1:0] sdram_addr,
   input  logic              err_clr,
   output logic              init_done,
   output logic              init_err,
   output logic [2:0]        err_code,
   output logic [3:0]        aref_count,
   output logic [ADDR_W-1:0] mode_reg
);
   localparam int T_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                         : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
   localparam int PW = (PWRUP_CYCLES > 0) ? $clog2(PWRUP_CYCLES + 1) : 1;
   localparam int GW = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_PWRUP, S_WAIT_PRE, S_TRP, S_WAIT_AREF, S_TRFC, S_WAIT_LMR, S_TMRD, S_DONE, S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic              en_q;
   logic [PW-1:0]     pwr_q, pwr_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [2:0]        code_q, code_d;
   logic [3:0]        aref_q, aref_d;
   logic [ADDR_W-1:0] mode_q, mode_d;
   logic              err_new;
   logic [2:0]        err_val;
   logic [2:0]        rcw;
   logic              is_nop, is_pre, is_aref, is_lmr;
   logic              more_now, more_after, acc_aref, acc_lmr;

   assign rcw        = {sdram_ras_n, sdram_cas_n, sdram_we_n};
   assign is_nop     = sdram_cs_n || rcw == 3'b111;
   assign is_pre     = !sdram_cs_n && rcw == 3'b010;
   assign is_aref    = !sdram_cs_n && rcw == 3'b001;
   assign is_lmr     = !sdram_cs_n && rcw == 3'b000;
   // more_now counts the refresh being accepted this cycle; more_after uses the already-updated count
   assign more_now   = (5'(aref_q) + 5'd1) < 5'(NUM_AREF);
   assign more_after = aref_q < 4'(NUM_AREF);

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         pwr_q   <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 3'd0;
         aref_q  <= 4'd0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= sdram_en;
         pwr_q   <= pwr_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         aref_q  <= aref_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pwr_d   = pwr_q;
      gap_d   = gap_q;
      tmo_d   = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
      err_new = 1'b0;
      err_val = 3'd0;
      if (!sdram_en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!en_q) begin
                  state_d = (PWRUP_CYCLES > 0) ? S_PWRUP : S_WAIT_PRE;
                  pwr_d   = '0;
                  tmo_d   = '0;
               end
            end
            S_PWRUP: begin
               if (!is_nop) {err_new, err_val} = {1'b1, 3'd1};
               else if (pwr_q == PW'(PWRUP_CYCLES - 1)) begin
                  state_d = S_WAIT_PRE;
                  tmo_d   = '0;
               end else pwr_d = pwr_q + 1'b1;
            end
            S_WAIT_PRE: begin
               if (is_pre && sdram_addr[10]) begin
                  state_d = (T_RP > 1) ? S_TRP : S_WAIT_AREF;
                  gap_d   = GW'(1);
               end else if (is_pre) {err_new, err_val} = {1'b1, 3'd4};
               else if (!is_nop) {err_new, err_val} = {1'b1, 3'd2};
            end
            S_TRP: begin
               if (!is_nop) {err_new, err_val} = {1'b1, 3'd3};
               else if (gap_q >= GW'(T_RP - 1)) state_d = S_WAIT_AREF;
               else gap_d = gap_q + 1'b1;
            end
            S_WAIT_AREF: begin
               if (is_aref) begin
                  state_d = (T_RFC > 1) ? S_TRFC : (more_now ? S_WAIT_AREF : S_WAIT_LMR);
                  gap_d   = GW'(1);
               end else if (!is_nop) {err_new, err_val} = {1'b1, 3'd2};
            end
            S_TRFC: begin
               if (!is_nop) {err_new, err_val} = {1'b1, 3'd3};
               else if (gap_q >= GW'(T_RFC - 1)) state_d = more_after ? S_WAIT_AREF : S_WAIT_LMR;
               else gap_d = gap_q + 1'b1;
            end
            S_WAIT_LMR: begin
               if (is_lmr) begin
                  state_d = (T_MRD > 0) ? S_TMRD : S_DONE;
                  gap_d   = GW'(1);
               end else if (!is_nop) {err_new, err_val} = {1'b1, 3'd2};
            end
            S_TMRD: begin
               if (gap_q >= GW'(T_MRD)) state_d = S_DONE;
               else if (!is_nop) {err_new, err_val} = {1'b1, 3'd3};
               else gap_d = gap_q + 1'b1;
            end
            default: ;
         endcase
         if (!err_new && TIMEOUT > 0 && tmo_q == TW'(TIMEOUT) &&
             state_q inside {S_WAIT_PRE, S_TRP, S_WAIT_AREF, S_TRFC, S_WAIT_LMR, S_TMRD})
            {err_new, err_val} = {1'b1, 3'd5};
         if (err_new) state_d = S_FAIL;
      end
   end

   always_comb begin
      acc_aref = sdram_en && state_q == S_WAIT_AREF && is_aref && !err_new;
      acc_lmr  = sdram_en && state_q == S_WAIT_LMR && is_lmr && !err_new;
      done_d   = state_d == S_DONE;
      aref_d   = !sdram_en ? 4'd0 : acc_aref ? aref_q + 4'd1 : aref_q;
      mode_d   = acc_lmr ? sdram_addr : mode_q;
      // a new error beats a simultaneous clear; otherwise only the first error is kept
      err_d    = err_new || (err_q && !err_clr);
      code_d   = err_new ? ((err_q && !err_clr) ? code_q : err_val) : (err_clr ? 3'd0 : code_q);
   end

   assign init_done  = done_q;
   assign init_err   = err_q;
   assign err_code   = code_q;
   assign aref_count = aref_q;
   assign mode_reg   = mode_q;
endmodule
